charge_timer: RTL

Parametrised coin-operated countdown timer for the charging station; successor to the fixed 1:59 / 9:59 counter. Accepts coin strobes that add credit to a saturating remaining-time balance, counts it down once per second in minutes:seconds BCD, supports cancel and optional pause, and flags completion. It sits between the coin acceptor and the display/relay controller.

---
 rtl/charge_timer.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/charge_timer.sv
// charge_timer: coin-operated countdown timer with a saturating seconds balance,
// minutes:seconds BCD display, cancel, and a completion pulse.
// Optional feature macro: CHARGE_TIMER_PAUSE_EN enables the Pause input and PAUSED state.
module charge_timer #(
  parameter int unsigned MIN_DIGITS = 2,
  parameter int unsigned MAX_MIN    = 30,
  parameter int unsigned TICK_DIV   = 50000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      coin_valid_i,
  input  logic [2:0]                coin_i,
  input  logic                      pause_i,
  input  logic                      cancel_i,
  output logic [4*MIN_DIGITS+7:0]   present_time_o,
  output logic                      active_o,
  output logic                      paused_o,
  output logic                      done_o,
  output logic                      rejected_o
);

  localparam int unsigned MAX_S = MAX_MIN * 60;
  localparam int unsigned BAL_W = $clog2(MAX_S + 1);
  localparam int unsigned PRE_W = $clog2(TICK_DIV);
  localparam int unsigned PT_W  = 4 * MIN_DIGITS + 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CHARGING = 2'd1,
    ST_PAUSED   = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [BAL_W-1:0]   bal_q, bal_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [PT_W-1:0]    pt_q;
  logic               active_q, done_q, rej_q, rej_d;
  logic               pause_c;
  logic               tick_c;
  int unsigned        credit_c;

  // Seconds credited by each coin code; zero marks an invalid code.
  function automatic int unsigned coin_value(input logic [2:0] code);
    case (code)
      3'd1:    return 30;
      3'd2:    return 60;
      3'd3:    return 120;
      3'd4:    return 300;
      default: return 0;
    endcase
  endfunction

  // Clamp a candidate balance to the credit ceiling.
  function automatic logic [BAL_W-1:0] sat(input int unsigned v);
    return (v > MAX_S) ? BAL_W'(MAX_S) : BAL_W'(v);
  endfunction

  // Balance in seconds to {BCD minutes, seconds tens, seconds ones}.
  function automatic logic [PT_W-1:0] to_pt(input logic [BAL_W-1:0] r);
    logic [PT_W-1:0] pt;
    int unsigned     m;
    int unsigned     s;
    pt = '0;
    m  = 32'(r) / 60;
    s  = 32'(r) % 60;
    for (int i = 0; i < int'(MIN_DIGITS); i++) begin
      pt[8 + 4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    pt[7:4] = 4'(s / 10);
    pt[3:0] = 4'(s % 10);
    return pt;
  endfunction

`ifdef CHARGE_TIMER_PAUSE_EN
  assign pause_c = pause_i;
`else
  logic pause_unused;
  assign pause_unused = pause_i;
  assign pause_c      = 1'b0;
`endif

  // State, balance and prescaler registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bal_q   <= '0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      bal_q   <= bal_d;
      presc_q <= presc_d;
    end
  end

  // Next state, balance arithmetic and prescaler control.
  always_comb begin
    state_d  = state_q;
    bal_d    = bal_q;
    presc_d  = presc_q;
    tick_c   = 1'b0;
    credit_c = coin_valid_i ? coin_value(coin_i) : 0;
    rej_d    = coin_valid_i && (coin_value(coin_i) == 0);
    if (cancel_i) begin
      state_d = ST_IDLE;
      bal_d   = '0;
      presc_d = '0;
      rej_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          presc_d = '0;
          if (credit_c != 0) begin
            state_d = ST_CHARGING;
            bal_d   = sat(credit_c);
          end else begin
            state_d = ST_IDLE;
            bal_d   = '0;
          end
        end
        ST_CHARGING: begin
          if (pause_c) begin
            state_d = ST_PAUSED;
            bal_d   = sat(32'(bal_q) + credit_c);
          end else begin
            tick_c  = (presc_q == PRE_W'(TICK_DIV - 1));
            presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
            bal_d   = sat(32'(bal_q) - 32'(tick_c) + credit_c);
            if (bal_d == '0) state_d = ST_DONE;
          end
        end
        ST_PAUSED: begin
          bal_d = sat(32'(bal_q) + credit_c);
          if (!pause_c) state_d = ST_CHARGING;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered outputs reflect the post-edge state and balance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q     <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      pt_q     <= to_pt(bal_d);
      active_q <= (state_d == ST_CHARGING);
      done_q   <= (state_d == ST_DONE);
      rej_q    <= rej_d;
    end
  end

`ifdef CHARGE_TIMER_PAUSE_EN
  logic paused_q;
  // Paused indicator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) paused_q <= 1'b0;
    else        paused_q <= (state_d == ST_PAUSED);
  end
  assign paused_o = paused_q;
`else
  assign paused_o = 1'b0;
`endif

  assign present_time_o = pt_q;
  assign active_o       = active_q;
  assign done_o         = done_q;
  assign rejected_o     = rej_q;

endmodule
